// File: rtl/usb_reg_pkg.sv
// usb_reg_pkg
// Shared definitions for the USB register bridge:
//   state_t          - bridge FSM encoding (IDLE / ADDR / ACTIVE)
//   SYNC_DEPTH       - number of flops in each control-strobe synchroniser
//   ERR_COUNT_WIDTH  - width of the protocol error counter
package usb_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam int SYNC_DEPTH      = 2;
   localparam int ERR_COUNT_WIDTH = 8;

endpackage

// File: rtl/usb_reg_bridge_sync.sv
// usb_sync_edge
// Brings one asynchronous control strobe into the clock domain through a
// SYNC_DEPTH-flop chain and reports registered edge flags.
// Ports:
//   clk      - sampling clock
//   rst_n    - asynchronous active-low reset (chain loads RESET_VAL)
//   async_in - asynchronous input strobe
//   sync_out - synchronised level
//   rise     - high on the first cycle sync_out reads 1 after a 0
//   fall     - high on the first cycle sync_out reads 0 after a 1
module usb_sync_edge
   import usb_reg_pkg::*;
#(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   // chain[0] is the first (metastable) stage, chain[SYNC_DEPTH-1] the output.
   logic [SYNC_DEPTH-1:0] chain;

   // Edge flags compare the stage about to become the output with the
   // current output, so each flag lines up with the first cycle of the new
   // sync_out level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {SYNC_DEPTH{RESET_VAL}};
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_DEPTH-2:0], async_in};
         rise  <= chain[SYNC_DEPTH-2] & ~chain[SYNC_DEPTH-1];
         fall  <= ~chain[SYNC_DEPTH-2] & chain[SYNC_DEPTH-1];
      end
   end

   assign sync_out = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/usb_reg_bridge.sv
// usb_reg_bridge
// Converts an asynchronous USB-controller bus (active-low ALEn/RDn/WRn/CEn)
// into single-cycle register read/write pulses with an address and a byte
// counter for burst accesses.
// Ports:
//   cwusb_clk, reset_n                    - clock, async active-low reset
//   cwusb_din/dout/isout                  - USB data in, data out, driver enable
//   cwusb_addr, cwusb_alen/rdn/wrn/cen    - USB address and strobes
//   reg_address/bytecnt/datao/datai       - register-side address, burst count, data
//   reg_read, reg_write                   - one-cycle access pulses
//   reg_addrvalid                         - high while an address phase is complete
//   err_clear, err_noaddr/collision/count - protocol error reporting
// Optional feature: define USB_REG_PROTOCOL_CHECK_EN to enable protocol
// error checking; otherwise the error outputs are tied to 0.
module usb_reg_bridge
   import usb_reg_pkg::*;
#(
   parameter int pADDR_WIDTH   = 8,
   parameter int pBYTECNT_SIZE = 7,
   parameter int pBYTECNT_WRAP = 1
) (
   input  logic                       cwusb_clk,
   input  logic                       reset_n,
   input  logic [7:0]                 cwusb_din,
   output logic [7:0]                 cwusb_dout,
   output logic                       cwusb_isout,
   input  logic [pADDR_WIDTH-1:0]     cwusb_addr,
   input  logic                       cwusb_rdn,
   input  logic                       cwusb_wrn,
   input  logic                       cwusb_alen,
   input  logic                       cwusb_cen,
   output logic [pADDR_WIDTH-1:0]     reg_address,
   output logic [pBYTECNT_SIZE-1:0]   reg_bytecnt,
   output logic [7:0]                 reg_datao,
   input  logic [7:0]                 reg_datai,
   output logic                       reg_read,
   output logic                       reg_write,
   output logic                       reg_addrvalid,
   input  logic                       err_clear,
   output logic                       err_noaddr,
   output logic                       err_collision,
   output logic [ERR_COUNT_WIDTH-1:0] err_count
);

   localparam logic [pBYTECNT_SIZE-1:0] BYTECNT_ONE = pBYTECNT_SIZE'(1);

   logic alen_s, rdn_s, wrn_s, cen_s;
   logic alen_rise, rdn_rise, wrn_rise;
   logic [4:0] unused_edges;

   usb_sync_edge #(.RESET_VAL(1'b1)) sync_alen (
      .clk(cwusb_clk), .rst_n(reset_n), .async_in(cwusb_alen),
      .sync_out(alen_s), .rise(alen_rise), .fall(unused_edges[0]));

   usb_sync_edge #(.RESET_VAL(1'b1)) sync_rdn (
      .clk(cwusb_clk), .rst_n(reset_n), .async_in(cwusb_rdn),
      .sync_out(rdn_s), .rise(rdn_rise), .fall(unused_edges[1]));

   usb_sync_edge #(.RESET_VAL(1'b1)) sync_wrn (
      .clk(cwusb_clk), .rst_n(reset_n), .async_in(cwusb_wrn),
      .sync_out(wrn_s), .rise(wrn_rise), .fall(unused_edges[2]));

   usb_sync_edge #(.RESET_VAL(1'b1)) sync_cen (
      .clk(cwusb_clk), .rst_n(reset_n), .async_in(cwusb_cen),
      .sync_out(cen_s), .rise(unused_edges[3]), .fall(unused_edges[4]));

   state_t state, state_nxt;
   logic   rd_cond, rd_q;
   logic   access, count_en;

   always_ff @(posedge cwusb_clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // A low ALEn pulls the bridge into ADDR from anywhere; releasing it
   // completes the address phase. ACTIVE is otherwise sticky.
   always_comb begin
      state_nxt = state;
      if (!alen_s)
         state_nxt = ST_ADDR;
      else if (state == ST_ADDR && alen_rise)
         state_nxt = ST_ACTIVE;
   end

   assign reg_addrvalid = (state == ST_ACTIVE);

   // Read fires on the first cycle of a selected read strobe, so the
   // register side can present data before the host samples it.
   assign rd_cond     = ~rdn_s & ~cen_s;
   assign reg_read    = rd_cond & ~rd_q;
   assign cwusb_isout = ~rdn_s | rdn_rise;

   // Accesses without a completed address phase still pulse but do not
   // advance the burst counter; a simultaneous read and write counts once.
   assign access   = reg_read | reg_write;
   assign count_en = access & reg_addrvalid;

   always_ff @(posedge cwusb_clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q        <= 1'b0;
         reg_write   <= 1'b0;
         reg_datao   <= '0;
         cwusb_dout  <= '0;
         reg_address <= '0;
         reg_bytecnt <= '0;
      end else begin
         rd_q      <= rd_cond;
         reg_write <= wrn_rise & ~cen_s;
         if (~cen_s & ~wrn_s)
            reg_datao <= cwusb_din;
         if (reg_read)
            cwusb_dout <= reg_datai;
         if (state == ST_ADDR) begin
            reg_address <= cwusb_addr;
            reg_bytecnt <= '0;
         end else if (count_en) begin
            if (reg_bytecnt != '1 || pBYTECNT_WRAP != 0)
               reg_bytecnt <= reg_bytecnt + BYTECNT_ONE;
         end
      end
   end

`ifdef USB_REG_PROTOCOL_CHECK_EN
   logic                       noaddr_evt, coll_evt;
   logic                       noaddr_q, coll_q;
   logic [ERR_COUNT_WIDTH-1:0] count_q, err_base;
   logic [ERR_COUNT_WIDTH:0]   err_sum;

   assign noaddr_evt = access & ~reg_addrvalid;
   assign coll_evt   = reg_read & reg_write;

   // Clear is applied before new events are added, so a coincident event
   // survives the clear. The extra sum bit detects saturation.
   assign err_base = err_clear ? '0 : count_q;
   assign err_sum  = {1'b0, err_base}
                   + {{ERR_COUNT_WIDTH{1'b0}}, noaddr_evt}
                   + {{ERR_COUNT_WIDTH{1'b0}}, coll_evt};

   always_ff @(posedge cwusb_clk or negedge reset_n) begin
      if (!reset_n) begin
         noaddr_q <= 1'b0;
         coll_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         noaddr_q <= (noaddr_q & ~err_clear) | noaddr_evt;
         coll_q   <= (coll_q & ~err_clear) | coll_evt;
         count_q  <= err_sum[ERR_COUNT_WIDTH] ? '1 : err_sum[ERR_COUNT_WIDTH-1:0];
      end
   end

   assign err_noaddr    = noaddr_q;
   assign err_collision = coll_q;
   assign err_count     = count_q;
`else
   logic unused_clear;
   assign unused_clear  = err_clear;
   assign err_noaddr    = 1'b0;
   assign err_collision = 1'b0;
   assign err_count     = '0;
`endif

endmodule

// File: tb/tb_usb_reg_bridge.sv
// tb_usb_reg_bridge
// Self-checking bench for usb_reg_bridge. A default instance carries the
// scoreboarded traffic; two 3-bit-counter instances (wrap / saturate) share
// the same bus for the counter boundary scenario.
module tb_usb_reg_bridge;

   typedef struct {
      logic [7:0] data;
      logic [6:0] cnt;
   } wr_exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] cwusb_din;
   logic [7:0] cwusb_addr;
   logic       cwusb_rdn, cwusb_wrn, cwusb_alen, cwusb_cen;
   logic [7:0] reg_datai;
   logic       err_clear;

   logic [7:0] cwusb_dout, reg_address, reg_datao, err_count;
   logic [6:0] reg_bytecnt;
   logic       cwusb_isout, reg_read, reg_write, reg_addrvalid;
   logic       err_noaddr, err_collision;

   logic [7:0] w_dout, w_address, w_datao, w_err_count;
   logic [2:0] w_bytecnt;
   logic       w_isout, w_read, w_write, w_addrvalid, w_err_noaddr, w_err_collision;
   logic [7:0] s_dout, s_address, s_datao, s_err_count;
   logic [2:0] s_bytecnt;
   logic       s_isout, s_read, s_write, s_addrvalid, s_err_noaddr, s_err_collision;

   int n_checks = 0;
   int n_fail   = 0;
   int model_cnt = 0;
   bit model_active = 1'b0;

   wr_exp_t    wr_q[$];
   logic [7:0] rd_q[$];
   bit         rd_pending = 1'b0;
   logic [7:0] rd_exp;

   always #5 clk = ~clk;

   usb_reg_bridge dut (
      .cwusb_clk(clk), .reset_n(reset_n), .cwusb_din(cwusb_din),
      .cwusb_dout(cwusb_dout), .cwusb_isout(cwusb_isout), .cwusb_addr(cwusb_addr),
      .cwusb_rdn(cwusb_rdn), .cwusb_wrn(cwusb_wrn), .cwusb_alen(cwusb_alen),
      .cwusb_cen(cwusb_cen), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
      .reg_datao(reg_datao), .reg_datai(reg_datai), .reg_read(reg_read),
      .reg_write(reg_write), .reg_addrvalid(reg_addrvalid), .err_clear(err_clear),
      .err_noaddr(err_noaddr), .err_collision(err_collision), .err_count(err_count));

   usb_reg_bridge #(.pBYTECNT_SIZE(3), .pBYTECNT_WRAP(1)) dut_wrap (
      .cwusb_clk(clk), .reset_n(reset_n), .cwusb_din(cwusb_din),
      .cwusb_dout(w_dout), .cwusb_isout(w_isout), .cwusb_addr(cwusb_addr),
      .cwusb_rdn(cwusb_rdn), .cwusb_wrn(cwusb_wrn), .cwusb_alen(cwusb_alen),
      .cwusb_cen(cwusb_cen), .reg_address(w_address), .reg_bytecnt(w_bytecnt),
      .reg_datao(w_datao), .reg_datai(reg_datai), .reg_read(w_read),
      .reg_write(w_write), .reg_addrvalid(w_addrvalid), .err_clear(err_clear),
      .err_noaddr(w_err_noaddr), .err_collision(w_err_collision), .err_count(w_err_count));

   usb_reg_bridge #(.pBYTECNT_SIZE(3), .pBYTECNT_WRAP(0)) dut_sat (
      .cwusb_clk(clk), .reset_n(reset_n), .cwusb_din(cwusb_din),
      .cwusb_dout(s_dout), .cwusb_isout(s_isout), .cwusb_addr(cwusb_addr),
      .cwusb_rdn(cwusb_rdn), .cwusb_wrn(cwusb_wrn), .cwusb_alen(cwusb_alen),
      .cwusb_cen(cwusb_cen), .reg_address(s_address), .reg_bytecnt(s_bytecnt),
      .reg_datao(s_datao), .reg_datai(reg_datai), .reg_read(s_read),
      .reg_write(s_write), .reg_addrvalid(s_addrvalid), .err_clear(err_clear),
      .err_noaddr(s_err_noaddr), .err_collision(s_err_collision), .err_count(s_err_count));

   // Scoreboard: each pulse from the main instance pops the expectation
   // pushed when its strobe was driven; read data is checked one cycle later.
   always @(negedge clk) begin
      if (rd_pending) begin
         n_checks++;
         if (cwusb_dout !== rd_exp) begin
            n_fail++;
            $display("[TB] FAIL read_dout: got %h expected %h", cwusb_dout, rd_exp);
         end
         rd_pending = 1'b0;
      end
      if (reg_write) begin
         n_checks++;
         if (wr_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_write: got reg_write=1 expected no pulse");
         end else begin
            wr_exp_t e;
            e = wr_q.pop_front();
            if (reg_datao !== e.data || reg_bytecnt !== e.cnt) begin
               n_fail++;
               $display("[TB] FAIL write_pulse: got data %h cnt %0d expected data %h cnt %0d",
                        reg_datao, reg_bytecnt, e.data, e.cnt);
            end
         end
      end
      if (reg_read) begin
         n_checks++;
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_read: got reg_read=1 expected no pulse");
         end else begin
            rd_exp     = rd_q.pop_front();
            rd_pending = 1'b1;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bump_model();
      if (model_active) model_cnt = (model_cnt + 1) % 128;
   endtask

   task automatic do_addr(input logic [7:0] a);
      cwusb_addr = a;
      cwusb_alen = 1'b0;
      cycles(4);
      cwusb_alen = 1'b1;
      cycles(4);
      model_active = 1'b1;
      model_cnt    = 0;
   endtask

   task automatic do_write(input logic [7:0] d);
      wr_exp_t e;
      e.data = d;
      e.cnt  = model_cnt[6:0];
      wr_q.push_back(e);
      bump_model();
      cwusb_din = d;
      cwusb_cen = 1'b0;
      cwusb_wrn = 1'b0;
      cycles(4);
      cwusb_wrn = 1'b1;
      cycles(3);
      cwusb_cen = 1'b1;
      cycles(3);
   endtask

   task automatic do_read(input logic [7:0] d);
      reg_datai = d;
      rd_q.push_back(d);
      bump_model();
      cwusb_cen = 1'b0;
      cwusb_rdn = 1'b0;
      cycles(4);
      n_checks++;
      if (cwusb_isout !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL isout_low: got %b expected 1", cwusb_isout);
      end
      cwusb_rdn = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cwusb_isout !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL isout_extra: got %b expected 1", cwusb_isout);
      end
      @(negedge clk);
      n_checks++;
      if (cwusb_isout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL isout_release: got %b expected 0", cwusb_isout);
      end
      cycles(2);
      cwusb_cen = 1'b1;
      cycles(3);
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      cwusb_alen = 1'b1; cwusb_rdn = 1'b1; cwusb_wrn = 1'b1; cwusb_cen = 1'b1;
      cwusb_din  = 8'h00; cwusb_addr = 8'h00; reg_datai = 8'h00; err_clear = 1'b0;
      cycles(3);
      n_checks++;
      if ({reg_address, reg_bytecnt, reg_datao, cwusb_dout} !== 31'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_regs: got %h expected 0",
                  {reg_address, reg_bytecnt, reg_datao, cwusb_dout});
      end
      reset_n = 1'b1;
      cycles(4);
      n_checks++;
      if ({reg_read, reg_write, reg_addrvalid, cwusb_isout} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got %b expected 0000",
                  {reg_read, reg_write, reg_addrvalid, cwusb_isout});
      end
   endtask

   task automatic test_protocol_errors();
      logic [9:0] exp_err;
      do_write(8'h77);
      n_checks++;
      if (reg_bytecnt !== 7'd0) begin
         n_fail++;
         $display("[TB] FAIL noaddr_cnt: got %0d expected 0", reg_bytecnt);
      end
      do_addr(8'h10);
      begin
         wr_exp_t e;
         e.data = 8'h99;
         e.cnt  = model_cnt[6:0];
         wr_q.push_back(e);
         rd_q.push_back(8'h3C);
         bump_model();
      end
      cwusb_din = 8'h99; reg_datai = 8'h3C;
      cwusb_cen = 1'b0; cwusb_wrn = 1'b0;
      cycles(4);
      cwusb_wrn = 1'b1;
      cycles(1);
      cwusb_rdn = 1'b0;
      cycles(4);
      cwusb_rdn = 1'b1;
      cycles(4);
      cwusb_cen = 1'b1;
      cycles(3);
      n_checks++;
      if (reg_bytecnt !== 7'd1) begin
         n_fail++;
         $display("[TB] FAIL collision_cnt: got %0d expected 1", reg_bytecnt);
      end
`ifdef USB_REG_PROTOCOL_CHECK_EN
      exp_err = {1'b1, 1'b1, 8'd2};
`else
      exp_err = 10'd0;
`endif
      n_checks++;
      if ({err_noaddr, err_collision, err_count} !== exp_err) begin
         n_fail++;
         $display("[TB] FAIL err_flags: got %h expected %h",
                  {err_noaddr, err_collision, err_count}, exp_err);
      end
      err_clear = 1'b1;
      cycles(1);
      err_clear = 1'b0;
      cycles(1);
      n_checks++;
      if ({err_noaddr, err_collision, err_count} !== 10'd0) begin
         n_fail++;
         $display("[TB] FAIL err_clear: got %h expected 0",
                  {err_noaddr, err_collision, err_count});
      end
   endtask

   task automatic test_write_burst();
      logic [7:0] burst [3];
      burst = '{8'h11, 8'h22, 8'h33};
      do_addr(8'h2A);
      n_checks++;
      if (reg_address !== 8'h2A || reg_addrvalid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL burst_addr: got %h/%b expected 2a/1", reg_address, reg_addrvalid);
      end
      for (int i = 0; i < 3; i++) do_write(burst[i]);
      n_checks++;
      if (reg_bytecnt !== 7'd3) begin
         n_fail++;
         $display("[TB] FAIL burst_cnt: got %0d expected 3", reg_bytecnt);
      end
   endtask

   task automatic test_read();
      do_addr(8'h05);
      do_read(8'hA5);
      do_read(8'h5A);
      n_checks++;
      if (reg_bytecnt !== 7'd2 || reg_address !== 8'h05) begin
         n_fail++;
         $display("[TB] FAIL read_cnt: got %0d/%h expected 2/05", reg_bytecnt, reg_address);
      end
   endtask

   task automatic test_wrap();
      do_addr(8'h00);
      for (int i = 0; i < 9; i++) do_write(8'(8'h40 + i));
      n_checks++;
      if (reg_bytecnt !== 7'd9) begin
         n_fail++;
         $display("[TB] FAIL cnt7_nine: got %0d expected 9", reg_bytecnt);
      end
      n_checks++;
      if (w_bytecnt !== 3'd1) begin
         n_fail++;
         $display("[TB] FAIL cnt3_wrap: got %0d expected 1", w_bytecnt);
      end
      n_checks++;
      if (s_bytecnt !== 3'd7) begin
         n_fail++;
         $display("[TB] FAIL cnt3_saturate: got %0d expected 7", s_bytecnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_addr(8'h33);
      do_write(8'h44);
      cwusb_din = 8'h55;
      cwusb_cen = 1'b0;
      cwusb_wrn = 1'b0;
      cycles(3);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({reg_address, reg_bytecnt, reg_datao, cwusb_dout} !== 31'd0) begin
         n_fail++;
         $display("[TB] FAIL midreset_regs: got %h expected 0",
                  {reg_address, reg_bytecnt, reg_datao, cwusb_dout});
      end
      n_checks++;
      if ({reg_read, reg_write, reg_addrvalid, cwusb_isout, err_noaddr, err_collision, err_count} !== 14'd0) begin
         n_fail++;
         $display("[TB] FAIL midreset_flags: got %h expected 0",
                  {reg_read, reg_write, reg_addrvalid, cwusb_isout, err_noaddr, err_collision, err_count});
      end
      cwusb_wrn = 1'b1;
      cwusb_cen = 1'b1;
      cycles(3);
      reset_n      = 1'b1;
      model_active = 1'b0;
      model_cnt    = 0;
      cycles(10);
      n_checks++;
      if (reg_addrvalid !== 1'b0 || reg_bytecnt !== 7'd0) begin
         n_fail++;
         $display("[TB] FAIL midreset_idle: got %b/%0d expected 0/0", reg_addrvalid, reg_bytecnt);
      end
      do_write(8'h66);
      n_checks++;
      if (reg_bytecnt !== 7'd0) begin
         n_fail++;
         $display("[TB] FAIL midreset_nocount: got %0d expected 0", reg_bytecnt);
      end
   endtask

   initial begin
      test_reset();
      test_protocol_errors();
      test_write_burst();
      test_read();
      test_wrap();
      test_reset_mid_burst();
      cycles(3);
      n_checks++;
      if (wr_q.size() != 0 || rd_q.size() != 0 || rd_pending) begin
         n_fail++;
         $display("[TB] FAIL missing_pulses: got %0d writes %0d reads outstanding expected 0",
                  wr_q.size(), rd_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usb_reg_bridge.md
USB_REG_BRIDGE -- requirements
Module: usb_reg_bridge

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 8, the width of the register address.
REQ-002 SHALL have parameter pBYTECNT_SIZE, default 7, the width of the byte counter.
REQ-003 SHALL have parameter pBYTECNT_WRAP, default 1; 1 = counter wraps, 0 = counter saturates.
REQ-004 SHALL have ports cwusb_clk in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have USB-side ports cwusb_din in 8; cwusb_dout out 8; cwusb_isout out 1 (output-driver enable); cwusb_addr in pADDR_WIDTH; cwusb_rdn, cwusb_wrn, cwusb_alen, cwusb_cen in 1 each, all active-low and asynchronous.
REQ-006 SHALL have register-side ports reg_address out pADDR_WIDTH; reg_bytecnt out pBYTECNT_SIZE; reg_datao out 8; reg_datai in 8; reg_read out 1 (pulse); reg_write out 1 (pulse); reg_addrvalid out 1.
REQ-007 SHALL have ports err_clear in 1; err_noaddr out 1; err_collision out 1; err_count out 8.

Function
REQ-008 SHALL pass alen, rdn, wrn and cen through 2-flop synchronisers (alen_s, rdn_s, wrn_s, cen_s); all decisions use the synchronised versions.
REQ-009 SHALL implement an FSM with states IDLE, ADDR and ACTIVE; ADDR is entered from any state while alen_s=0; ADDR->ACTIVE on alen_s rising; ACTIVE is held until alen_s=0.
REQ-010 SHALL latch reg_address from cwusb_addr on every cycle spent in ADDR.
REQ-011 SHALL assert reg_addrvalid exactly while in ACTIVE.
REQ-012 SHALL capture reg_datao from cwusb_din on each cycle with cen_s=0 and wrn_s=0.
REQ-013 SHALL pulse reg_write for one cycle, one cycle after wrn_s rises while cen_s=0.
REQ-014 SHALL pulse reg_read for one cycle on the first cycle of (rdn_s=0 and cen_s=0).
REQ-015 SHALL register reg_datai into cwusb_dout the cycle after reg_read and hold it until the next read.
REQ-016 SHALL drive cwusb_isout while rdn_s=0, plus one further cycle after rdn_s rises.
REQ-017 SHALL clear reg_bytecnt to 0 on every cycle in ADDR.
REQ-018 SHALL increment reg_bytecnt by 1, one cycle after each reg_read or reg_write pulse.
REQ-019 SHALL, at all-ones, wrap reg_bytecnt to 0 when pBYTECNT_WRAP=1, and hold it when pBYTECNT_WRAP=0.
REQ-020 SHALL still pulse reg_read and reg_write when either pulse occurs outside ACTIVE, and SHALL NOT increment reg_bytecnt for that pulse.
REQ-021 SHALL, when reg_read and reg_write pulse in the same cycle, increment reg_bytecnt once only.

Reset
REQ-022 SHALL, on reset_n=0, immediately force FSM=IDLE; reg_address, reg_bytecnt, reg_datao and cwusb_dout=0; reg_read, reg_write, reg_addrvalid and cwusb_isout=0; all error outputs=0.
REQ-023 SHALL initialise synchronisers on reset to their inactive (high) value, so that no pulse occurs on release.
REQ-024 SHALL, on reset mid-transfer, abort the access: no pulse on release, and a new ADDR phase is required before further counting.

Configuration
REQ-025 SHALL implement protocol checking when USB_REG_PROTOCOL_CHECK_EN is defined, as follows:
- err_noaddr is set sticky on a REQ-020 access.
- err_collision is set sticky on a REQ-021 event.
- err_count saturates at 255 and counts each such event.
- err_clear=1 zeroes all three error outputs (set wins if simultaneous).
REQ-026 SHALL, without USB_REG_PROTOCOL_CHECK_EN, tie err_noaddr, err_collision and err_count to 0 and ignore err_clear.

Structure
REQ-027 SHALL place the FSM state encoding, the synchroniser depth constant (2) and the error-count width (8) in the shared package usb_reg_pkg.
REQ-028 SHALL use one sub-module, usb_sync_edge: parametrised reset value, 2-flop synchroniser, registered rise/fall outputs, instantiated once per control input.

Verification
REQ-029 SHALL cover an address-then-write-burst scenario:
- Stimulus: alen low with addr=0x2A, alen high, then 3 write strobes with din 0x11/0x22/0x33.
- Response: reg_address=0x2A; 3 reg_write pulses carrying datao 0x11/0x22/0x33 at bytecnt 0/1/2; final bytecnt=3.
REQ-030 SHALL cover a read scenario:
- Stimulus: addr 0x05, then 2 read strobes with reg_datai 0xA5 then 0x5A.
- Response: 2 reg_read pulses; cwusb_dout=0xA5 then 0x5A; isout stays high for 1 cycle past each rdn rise; bytecnt=2.
REQ-031 SHALL cover counter wrap and saturation with pBYTECNT_SIZE=3:
- Stimulus: 9 writes.
- Response: bytecnt=1 when pBYTECNT_WRAP=1; bytecnt=7 when pBYTECNT_WRAP=0.
REQ-032 SHALL cover protocol errors with the macro defined:
- Stimulus: a write with no ALEn phase since reset, then simultaneous rd/wr.
- Response: err_noaddr=1, err_collision=1, err_count=2, bytecnt=1; err_clear then zeroes all three.
REQ-033 SHALL cover reset mid-burst:
- Stimulus: assert reset_n low during the 2nd write strobe.
- Response: all outputs 0 asynchronously; no reg_write pulse after release; FSM=IDLE.
